// File: rtl/comptest_pkg.sv
// comptest_pkg: shared triad decoder state encoding and parameter defaults
package comptest_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2
  } state_e;
  localparam int NCH_DEF  = 8;
  localparam int PW_DEF   = 4;
  localparam int CNTW_DEF = 16;
endpackage

// File: rtl/triad_decode_ch.sv
// triad_decode_ch: one-channel serial triad decoder with output hold, skip detect and skip counter
//   lctrst_i       sync decoder reset (FSM, hold, skip pulse)
//   persist_i      hold length minus one, sampled when a triad completes
//   distrip_i      serial triad input
//   skip_cnt_clr_i sync clear of the skip counter
//   hs_o           one-hot decoded halfstrip, held persist+1 cycles
//   skip_o         one-cycle pulse per dropped triad
//   skip_cnt_o     saturating count of dropped triads
module triad_decode_ch
  import comptest_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lctrst_i,
  input  logic [PW-1:0]   persist_i,
  input  logic            distrip_i,
  input  logic            skip_cnt_clr_i,
  output logic [3:0]      hs_o,
  output logic            skip_o,
  output logic [CNTW-1:0] skip_cnt_o
);
  state_e          state_q, state_d;
  logic            b1_q, b1_d;
  logic [3:0]      hs_q, hs_d;
  logic [PW-1:0]   hold_q, hold_d;
  logic            skip_q, skip_d;
  logic [CNTW-1:0] sc_q, sc_d;
  logic            done, busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b1_q    <= 1'b0;
      hs_q    <= '0;
      hold_q  <= '0;
      skip_q  <= 1'b0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      b1_q    <= b1_d;
      hs_q    <= hs_d;
      hold_q  <= hold_d;
      skip_q  <= skip_d;
      sc_q    <= sc_d;
    end
  end
  // busy: the current hit is still shown next cycle, so a completing triad must be dropped
  always_comb begin
    busy    = hold_q != '0;
    done    = state_q == B2 && !lctrst_i;
    state_d = lctrst_i ? IDLE :
              state_q == IDLE ? (distrip_i ? B1 : IDLE) :
              state_q == B1 ? B2 : IDLE;
    b1_d    = state_q == B1 ? distrip_i : b1_q;
    hs_d    = lctrst_i ? '0 : done && !busy ? 4'b0001 << {b1_q, distrip_i} : busy ? hs_q : '0;
    hold_d  = lctrst_i ? '0 : done && !busy ? persist_i : busy ? hold_q - PW'(1) : '0;
    skip_d  = done && busy;
    // a skip coinciding with the clear is counted as the first event after it
    sc_d    = skip_cnt_clr_i ? CNTW'(skip_q) : skip_q && !(&sc_q) ? sc_q + CNTW'(1) : sc_q;
  end
  assign hs_o       = hs_q;
  assign skip_o     = skip_q;
  assign skip_cnt_o = sc_q;
endmodule

// File: rtl/triad_decoder_bank.sv
// triad_decoder_bank: bank of independent triad decoders with hit accumulator and skip summary
//   _reset        async active-low reset, release synchronised by two flops
//   lctrst        sync decoder reset (keeps hs_accum and skip_cnt)
//   persist       hit hold length minus one
//   distrip       serial triad inputs, one per channel
//   halfstrips    decoded hits, channel i owns [4i+3:4i]
//   triad_skip    per-channel dropped-triad pulse
//   skip_any      registered OR of triad_skip
//   hs_accum      sticky OR of halfstrips, cleared by accum_clr
//   skip_cnt      per-channel saturating skip counters, cleared by skip_cnt_clr
module triad_decoder_bank
  import comptest_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int PW   = PW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                clk,
  input  logic                _reset,
  input  logic                lctrst,
  input  logic [PW-1:0]       persist,
  input  logic [NCH-1:0]      distrip,
  output logic [4*NCH-1:0]    halfstrips,
  output logic [NCH-1:0]      triad_skip,
  output logic                skip_any,
  output logic [4*NCH-1:0]    hs_accum,
  input  logic                accum_clr,
  output logic [NCH*CNTW-1:0] skip_cnt,
  input  logic                skip_cnt_clr
);
  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  logic [4*NCH-1:0]     hs_accum_q;
  logic                 skip_any_q;
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_accum_q <= '0;
      skip_any_q <= 1'b0;
    end else begin
      hs_accum_q <= accum_clr ? halfstrips : hs_accum_q | halfstrips;
      skip_any_q <= !lctrst && |triad_skip;
    end
  end
  assign hs_accum = hs_accum_q;
  assign skip_any = skip_any_q;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    triad_decode_ch #(.PW(PW), .CNTW(CNTW)) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .lctrst_i      (lctrst),
      .persist_i     (persist),
      .distrip_i     (distrip[i]),
      .skip_cnt_clr_i(skip_cnt_clr),
      .hs_o          (halfstrips[4*i +: 4]),
      .skip_o        (triad_skip[i]),
      .skip_cnt_o    (skip_cnt[CNTW*i +: CNTW])
    );
  end
endmodule
